// File: rtl/tiger_clz_unit_if.sv
// Handshake bundle for tiger_clz_unit: operand side (in_*) and result side (out_*).
// out_norm is present only when TIGER_CLZ_NORM_EN is defined.
interface tiger_clz_unit_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_src;
    logic             in_ones;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_count;
    logic [TAG_W-1:0] out_tag;
`ifdef TIGER_CLZ_NORM_EN
    logic [31:0]      out_norm;

    modport slave (
        input  in_valid, in_src, in_ones, in_tag, out_ready,
        output in_ready, out_valid, out_count, out_tag, out_norm
    );

    modport master (
        output in_valid, in_src, in_ones, in_tag, out_ready,
        input  in_ready, out_valid, out_count, out_tag, out_norm
    );
`else
    modport slave (
        input  in_valid, in_src, in_ones, in_tag, out_ready,
        output in_ready, out_valid, out_count, out_tag
    );

    modport master (
        output in_valid, in_src, in_ones, in_tag, out_ready,
        input  in_ready, out_valid, out_count, out_tag
    );
`endif
endinterface

// File: rtl/tiger_clz_unit.sv
// Two-stage pipelined CLZ/CLO unit (MIPS32) with valid/ready handshake and flush.
// Define TIGER_CLZ_NORM_EN to also produce the normalised word on out_norm.
module tiger_clz_unit #(
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    tiger_clz_unit_if.slave bus
);

    // Stage-1 operand preparation
    logic [31:0]      x;
    logic             x_hi_zero;
    logic             x_zero;
    logic [15:0]      x_half;

    // Pipeline control
    logic             s1_valid;
    logic             out_valid_q;
    logic             s2_load;
    logic             in_ready_c;
    logic             in_fire;

    // Stage-1 registers
    logic             s1_hi;
    logic             s1_zero;
    logic [15:0]      s1_half;
    logic [TAG_W-1:0] s1_tag;

    // Stage-2 resolution of the low four count bits
    logic [3:0]       cnt_lo;
    logic [5:0]       count_c;
    logic [5:0]       out_count_q;
    logic [TAG_W-1:0] out_tag_q;

    always_comb begin
        x         = bus.in_ones ? ~bus.in_src : bus.in_src;
        x_hi_zero = (x[31:16] == '0);
        x_zero    = (x == '0);
        x_half    = x_hi_zero ? x[15:0] : x[31:16];
    end

    // Stage 2 takes a new entry whenever it is empty or being drained.
    always_comb begin
        s2_load    = ~out_valid_q | bus.out_ready;
        in_ready_c = ~s1_valid | s2_load;
        in_fire    = bus.in_valid & in_ready_c;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_tag   = out_tag_q;

    // Valid bits: reset beats flush, flush beats every transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (in_fire)
                s1_valid <= 1'b1;
            else if (s2_load)
                s1_valid <= 1'b0;
            if (s2_load)
                out_valid_q <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_hi   <= x_hi_zero;
            s1_zero <= x_zero;
            s1_half <= x_half;
            s1_tag  <= bus.in_tag;
        end
    end

    // Binary search 8/4/2/1 on the retained half-word.
    always_comb begin
        logic [7:0] h8;
        logic [3:0] h4;
        logic [1:0] h2;
        cnt_lo[3] = (s1_half[15:8] == '0);
        h8        = cnt_lo[3] ? s1_half[7:0] : s1_half[15:8];
        cnt_lo[2] = (h8[7:4] == '0);
        h4        = cnt_lo[2] ? h8[3:0] : h8[7:4];
        cnt_lo[1] = (h4[3:2] == '0);
        h2        = cnt_lo[1] ? h4[1:0] : h4[3:2];
        cnt_lo[0] = ~h2[1];
        count_c   = s1_zero ? 6'd32 : {1'b0, s1_hi, cnt_lo};
    end

    // Output registers only move on a real stage-1 to stage-2 transfer, so they hold under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_count_q <= '0;
            out_tag_q   <= '0;
        end else if (~flush && s2_load && s1_valid) begin
            out_count_q <= count_c;
            out_tag_q   <= s1_tag;
        end
    end

`ifdef TIGER_CLZ_NORM_EN
    logic [31:0] s1_norm;
    logic [31:0] norm_c;
    logic [31:0] out_norm_q;

    always_ff @(posedge clk) begin
        if (in_fire)
            s1_norm <= x_hi_zero ? {bus.in_src[15:0], 16'h0000} : bus.in_src;
    end

    // Residual shift follows the same bits as the count; an all-zero/all-one operand forces zero.
    always_comb begin
        norm_c = s1_norm;
        if (cnt_lo[3]) norm_c = {norm_c[23:0], 8'h00};
        if (cnt_lo[2]) norm_c = {norm_c[27:0], 4'h0};
        if (cnt_lo[1]) norm_c = {norm_c[29:0], 2'b00};
        if (cnt_lo[0]) norm_c = {norm_c[30:0], 1'b0};
        if (s1_zero)   norm_c = '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            out_norm_q <= '0;
        else if (~flush && s2_load && s1_valid)
            out_norm_q <= norm_c;
    end

    assign bus.out_norm = out_norm_q;
`endif

endmodule
